change_dispenser: RTL

CHANGE_DISPENSER -- requirements
Module: change_dispenser

---
 rtl/vending_pkg.sv | 36 +++
 rtl/change_dispenser_if.sv | 34 +++
 rtl/coin_counter.sv | 30 +++
 rtl/change_dispenser.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/vending_pkg.sv
// Shared definitions for the vending machine: coin values, the one-hot
// eject encoding and the dispenser state encoding.
package vending_pkg;

  localparam int AMT_W = 5;
  localparam int INV_W = 6;

  localparam logic [AMT_W-1:0] COIN_VAL_1  = 5'd1;
  localparam logic [AMT_W-1:0] COIN_VAL_5  = 5'd5;
  localparam logic [AMT_W-1:0] COIN_VAL_10 = 5'd10;

  typedef enum logic [2:0] {
    COIN_NONE = 3'b000,
    COIN_1    = 3'b001,
    COIN_5    = 3'b010,
    COIN_10   = 3'b100
  } coin_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SELECT,
    ST_EJECT,
    ST_WAIT_REL,
    ST_DONE
  } state_e;

  function automatic logic [AMT_W-1:0] coin_value(input coin_e c);
    case (c)
      COIN_1:  return COIN_VAL_1;
      COIN_5:  return COIN_VAL_5;
      COIN_10: return COIN_VAL_10;
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/change_dispenser_if.sv
// Handshake bundle between the upstream vending FSM (master) and the
// change dispenser (slave), including the eject mechanism and refill.
interface change_dispenser_if;
  import vending_pkg::*;

  logic             i_start;
  logic [AMT_W-1:0] i_amount;
  logic             i_ack;
  logic             i_refill;
  logic [INV_W-1:0] i_refill_cnt;

  logic [2:0]       o_coin;
  logic             o_busy;
  logic             o_done;
  logic             o_short;
  logic             o_fault;
  logic [AMT_W-1:0] o_remain;
  logic [INV_W-1:0] o_inv_1;
  logic [INV_W-1:0] o_inv_5;
  logic [INV_W-1:0] o_inv_10;

  modport master (
    output i_start, i_amount, i_ack, i_refill, i_refill_cnt,
    input  o_coin, o_busy, o_done, o_short, o_fault, o_remain,
           o_inv_1, o_inv_5, o_inv_10
  );

  modport slave (
    input  i_start, i_amount, i_ack, i_refill, i_refill_cnt,
    output o_coin, o_busy, o_done, o_short, o_fault, o_remain,
           o_inv_1, o_inv_5, o_inv_10
  );

endinterface

// File: rtl/coin_counter.sv
// Inventory of one coin denomination: loadable, decrements by one per
// ejected coin and never wraps below zero.
module coin_counter
  import vending_pkg::*;
#(
  parameter int INIT = 20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [INV_W-1:0] load_val,
  input  logic             dec,
  output logic [INV_W-1:0] count,
  output logic             nonzero
);

  // Reset restores the initial stock; a load wins over a decrement.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= INV_W'(INIT);
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign nonzero = (count != '0);

endmodule

// File: rtl/change_dispenser.sv
// Change dispenser: pays an amount greedily in 1 yuan, 5 jiao and 1 jiao
// coins, one eject/ack handshake per coin, with shortage and ack-timeout
// reporting.
module change_dispenser
  import vending_pkg::*;
#(
  parameter int INIT_INV    = 20,
  parameter int ACK_TIMEOUT = 200
) (
  input logic               clk,
  input logic               reset,
  change_dispenser_if.slave bus
);

  localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(ACK_TIMEOUT - 1);

  state_e           state;
  coin_e            coin_q;
  coin_e            sel_q;
  coin_e            pick;
  logic             done_q;
  logic             short_q;
  logic             fault_q;
  logic [AMT_W-1:0] remain_q;
  logic [CNT_W-1:0] wait_cnt;

  logic             refill_take;
  logic             ack_take;
  logic [INV_W-1:0] inv_1;
  logic [INV_W-1:0] inv_5;
  logic [INV_W-1:0] inv_10;
  logic             nz_1;
  logic             nz_5;
  logic             nz_10;

  assign refill_take = (state == ST_IDLE) && bus.i_refill;
  assign ack_take    = (state == ST_EJECT) && bus.i_ack;

  coin_counter #(.INIT(INIT_INV)) u_inv_1 (
    .clk      (clk),
    .reset    (reset),
    .load     (refill_take),
    .load_val (bus.i_refill_cnt),
    .dec      (ack_take && (sel_q == COIN_1)),
    .count    (inv_1),
    .nonzero  (nz_1)
  );

  coin_counter #(.INIT(INIT_INV)) u_inv_5 (
    .clk      (clk),
    .reset    (reset),
    .load     (refill_take),
    .load_val (bus.i_refill_cnt),
    .dec      (ack_take && (sel_q == COIN_5)),
    .count    (inv_5),
    .nonzero  (nz_5)
  );

  coin_counter #(.INIT(INIT_INV)) u_inv_10 (
    .clk      (clk),
    .reset    (reset),
    .load     (refill_take),
    .load_val (bus.i_refill_cnt),
    .dec      (ack_take && (sel_q == COIN_10)),
    .count    (inv_10),
    .nonzero  (nz_10)
  );

  // Largest coin that still fits the amount owed and is in stock.
  always_comb begin
    pick = COIN_NONE;
    if ((remain_q >= COIN_VAL_10) && nz_10) begin
      pick = COIN_10;
    end else if ((remain_q >= COIN_VAL_5) && nz_5) begin
      pick = COIN_5;
    end else if ((remain_q >= COIN_VAL_1) && nz_1) begin
      pick = COIN_1;
    end
  end

  // Payout sequencer; every output flag is a registered state decode.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      coin_q   <= COIN_NONE;
      sel_q    <= COIN_NONE;
      done_q   <= 1'b0;
      short_q  <= 1'b0;
      fault_q  <= 1'b0;
      remain_q <= '0;
      wait_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.i_start) begin
            remain_q <= bus.i_amount;
            short_q  <= 1'b0;
            fault_q  <= 1'b0;
            state    <= ST_SELECT;
          end
        end
        ST_SELECT: begin
          wait_cnt <= '0;
          if (remain_q == '0) begin
            done_q <= 1'b1;
            state  <= ST_DONE;
          end else if (pick == COIN_NONE) begin
            short_q <= 1'b1;
            done_q  <= 1'b1;
            state   <= ST_DONE;
          end else begin
            sel_q  <= pick;
            coin_q <= pick;
            state  <= ST_EJECT;
          end
        end
        ST_EJECT: begin
          if (bus.i_ack) begin
            remain_q <= remain_q - coin_value(sel_q);
            coin_q   <= COIN_NONE;
            wait_cnt <= '0;
            state    <= ST_WAIT_REL;
          end else if (wait_cnt == TIMEOUT_LAST) begin
            fault_q  <= 1'b1;
            coin_q   <= COIN_NONE;
            wait_cnt <= '0;
            done_q   <= 1'b1;
            state    <= ST_DONE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        ST_WAIT_REL: begin
          if (!bus.i_ack) begin
            state <= ST_SELECT;
          end
        end
        ST_DONE: begin
          done_q <= 1'b0;
          state  <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.o_coin   = coin_q;
  assign bus.o_busy   = (state != ST_IDLE);
  assign bus.o_done   = done_q;
  assign bus.o_short  = short_q;
  assign bus.o_fault  = fault_q;
  assign bus.o_remain = remain_q;
  assign bus.o_inv_1  = inv_1;
  assign bus.o_inv_5  = inv_5;
  assign bus.o_inv_10 = inv_10;

endmodule
